// File: rtl/regfile_access_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_access_ctrl
//
// Sequencing and arbitration controller in front of the single-write,
// two-read 16x32 register file of the multi-cycle processor.
//
// Two requesters share the file:
//   requester 0 : control-unit datapath
//   requester 1 : load/debug path
// Each one issues either a read-pair (RA, RB) or a single write (RW, BusW).
// The controller grants one operation at a time, round-robin. It latches the
// granted operation and drives the register file ports from those latches. It
// also absorbs the file's registered read latency and returns the result with
// a one-cycle response pulse.
//
// Ports:
//   clock, reset              system clock; synchronous active-high reset
//   reqN_valid / reqN_ready   request handshake, accepted when both are high
//   reqN_write                1 = write, 0 = read-pair
//   reqN_ra, reqN_rb          read indices
//   reqN_rw, reqN_wdata       write index and write data
//   rsp_valid                 one-cycle completion pulse
//   rsp_id                    requester that owns the response
//   rsp_write                 completed operation was a write
//   rsp_err                   write targeted R0 and was dropped
//   rsp_a, rsp_b              read data (0 for writes), held until next rsp
//   rf_RegWr, rf_RA, rf_RB,
//   rf_RW, rf_BusW            register file control/write side
//   rf_BusA, rf_BusB          register file read data (registered in file)
//
// Parameters:
//   DATA_W  register data width
//   ADDR_W  register index width
//   RD_LAT  clock edges from presenting RA/RB to BusA/BusB valid (1..3)
// ---------------------------------------------------------------------------
module regfile_access_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_ra,
  input  logic [ADDR_W-1:0] req0_rb,
  input  logic [ADDR_W-1:0] req0_rw,
  input  logic [DATA_W-1:0] req0_wdata,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_ra,
  input  logic [ADDR_W-1:0] req1_rb,
  input  logic [ADDR_W-1:0] req1_rw,
  input  logic [DATA_W-1:0] req1_wdata,

  output logic              rsp_valid,
  output logic              rsp_id,
  output logic              rsp_write,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_a,
  output logic [DATA_W-1:0] rsp_b,

  output logic              rf_RegWr,
  output logic [ADDR_W-1:0] rf_RA,
  output logic [ADDR_W-1:0] rf_RB,
  output logic [ADDR_W-1:0] rf_RW,
  output logic [DATA_W-1:0] rf_BusW,
  input  logic [DATA_W-1:0] rf_BusA,
  input  logic [DATA_W-1:0] rf_BusB
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    CAPT  = 2'd3
  } state_t;

  // Two bits cover the supported RD_LAT range of 1..3.
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t state;
  state_t state_next;

  logic [1:0] rd_cnt;
  logic       last_grant;

  // Latched copy of the granted operation.
  logic              lat_id;
  logic [ADDR_W-1:0] lat_ra;
  logic [ADDR_W-1:0] lat_rb;
  logic [ADDR_W-1:0] lat_rw;
  logic [DATA_W-1:0] lat_wdata;

  // Arbitration results and the winner's fields.
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              win_id;
  logic              win_write;
  logic [ADDR_W-1:0] win_ra;
  logic [ADDR_W-1:0] win_rb;
  logic [ADDR_W-1:0] win_rw;
  logic [DATA_W-1:0] win_wdata;

  // State register. Reset discards any operation in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A write spends exactly one cycle in WRITE. A read
  // spends RD_LAT cycles in READ while the file's read pipeline fills, then
  // one cycle in CAPT while BusA/BusB are valid.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = win_write ? WRITE : READ;
        end
      end
      WRITE: begin
        state_next = IDLE;
      end
      READ: begin
        if (rd_cnt == 2'd0) begin
          state_next = CAPT;
        end
      end
      CAPT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic: grant generation and the write strobe.
  // Grants are only offered in IDLE. On a tie, the requester that did not win
  // last time gets the grant. Reset is folded into the write strobe so that a
  // reset landing on the WRITE cycle keeps the file from committing at that
  // edge. Writes to R0 are never strobed into the file.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if ((state == IDLE) && !reset) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
    rf_RegWr = (state == WRITE) && !reset && (lat_rw != '0);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Winner selection. Only one grant is ever high, so grant1 alone picks
  // the source of the fields.
  always_comb begin
    accept = grant0 | grant1;
    win_id = grant1;
    if (grant1) begin
      win_write = req1_write;
      win_ra    = req1_ra;
      win_rb    = req1_rb;
      win_rw    = req1_rw;
      win_wdata = req1_wdata;
    end else begin
      win_write = req0_write;
      win_ra    = req0_ra;
      win_rb    = req0_rb;
      win_rw    = req0_rw;
      win_wdata = req0_wdata;
    end
  end

  // Operation latches, round-robin pointer and read latency counter.
  // The latches are only loaded on an accept, so the file ports hold their
  // last value outside active states. last_grant resets to 1 so that
  // requester 0 wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
      rd_cnt     <= 2'd0;
      lat_id     <= 1'b0;
      lat_ra     <= '0;
      lat_rb     <= '0;
      lat_rw     <= '0;
      lat_wdata  <= '0;
    end else if (accept) begin
      last_grant <= win_id;
      rd_cnt     <= CNT_INIT;
      lat_id     <= win_id;
      lat_ra     <= win_ra;
      lat_rb     <= win_rb;
      lat_rw     <= win_rw;
      lat_wdata  <= win_wdata;
    end else if ((state == READ) && (rd_cnt != 2'd0)) begin
      rd_cnt <= rd_cnt - 2'd1;
    end
  end

  // Response register. rsp_valid pulses for one cycle at the closing edge of
  // WRITE or CAPT. The data fields are only updated on a response, so they
  // hold until the next one.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_a     <= '0;
      rsp_b     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == WRITE) begin
        rsp_valid <= 1'b1;
        rsp_id    <= lat_id;
        rsp_write <= 1'b1;
        rsp_err   <= (lat_rw == '0);
        rsp_a     <= '0;
        rsp_b     <= '0;
      end else if (state == CAPT) begin
        rsp_valid <= 1'b1;
        rsp_id    <= lat_id;
        rsp_write <= 1'b0;
        rsp_err   <= 1'b0;
        rsp_a     <= rf_BusA;
        rsp_b     <= rf_BusB;
      end
    end
  end

  assign rf_RA   = lat_ra;
  assign rf_RB   = lat_rb;
  assign rf_RW   = lat_rw;
  assign rf_BusW = lat_wdata;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_access_ctrl
//
// Directed testbench for regfile_access_ctrl. Two instances are built:
// d1 with RD_LAT=1 and d3 with RD_LAT=3. Each one has a behavioural register
// file attached whose read path is registered with the matching latency. The
// register file powers up with R[i] = i, so R0 = 0.
// ---------------------------------------------------------------------------
module tb_regfile_access_ctrl;

  logic clock;
  logic reset;

  int tests_run;
  int tests_failed;

  // d1 (RD_LAT = 1)
  logic        d1_req0_valid, d1_req0_ready, d1_req0_write;
  logic [3:0]  d1_req0_ra, d1_req0_rb, d1_req0_rw;
  logic [31:0] d1_req0_wdata;
  logic        d1_req1_valid, d1_req1_ready, d1_req1_write;
  logic [3:0]  d1_req1_ra, d1_req1_rb, d1_req1_rw;
  logic [31:0] d1_req1_wdata;
  logic        d1_rsp_valid, d1_rsp_id, d1_rsp_write, d1_rsp_err;
  logic [31:0] d1_rsp_a, d1_rsp_b;
  logic        d1_rf_RegWr;
  logic [3:0]  d1_rf_RA, d1_rf_RB, d1_rf_RW;
  logic [31:0] d1_rf_BusW, d1_rf_BusA, d1_rf_BusB;

  // d3 (RD_LAT = 3), only requester 0 is used
  logic        d3_req0_valid, d3_req0_ready, d3_req0_write;
  logic [3:0]  d3_req0_ra, d3_req0_rb, d3_req0_rw;
  logic [31:0] d3_req0_wdata;
  logic        d3_req1_ready;
  logic        d3_rsp_valid, d3_rsp_id, d3_rsp_write, d3_rsp_err;
  logic [31:0] d3_rsp_a, d3_rsp_b;
  logic        d3_rf_RegWr;
  logic [3:0]  d3_rf_RA, d3_rf_RB, d3_rf_RW;
  logic [31:0] d3_rf_BusW, d3_rf_BusA, d3_rf_BusB;

  regfile_access_ctrl #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1)) d1 (
    .clock(clock), .reset(reset),
    .req0_valid(d1_req0_valid), .req0_ready(d1_req0_ready), .req0_write(d1_req0_write),
    .req0_ra(d1_req0_ra), .req0_rb(d1_req0_rb), .req0_rw(d1_req0_rw), .req0_wdata(d1_req0_wdata),
    .req1_valid(d1_req1_valid), .req1_ready(d1_req1_ready), .req1_write(d1_req1_write),
    .req1_ra(d1_req1_ra), .req1_rb(d1_req1_rb), .req1_rw(d1_req1_rw), .req1_wdata(d1_req1_wdata),
    .rsp_valid(d1_rsp_valid), .rsp_id(d1_rsp_id), .rsp_write(d1_rsp_write), .rsp_err(d1_rsp_err),
    .rsp_a(d1_rsp_a), .rsp_b(d1_rsp_b),
    .rf_RegWr(d1_rf_RegWr), .rf_RA(d1_rf_RA), .rf_RB(d1_rf_RB), .rf_RW(d1_rf_RW),
    .rf_BusW(d1_rf_BusW), .rf_BusA(d1_rf_BusA), .rf_BusB(d1_rf_BusB)
  );

  regfile_access_ctrl #(.DATA_W(32), .ADDR_W(4), .RD_LAT(3)) d3 (
    .clock(clock), .reset(reset),
    .req0_valid(d3_req0_valid), .req0_ready(d3_req0_ready), .req0_write(d3_req0_write),
    .req0_ra(d3_req0_ra), .req0_rb(d3_req0_rb), .req0_rw(d3_req0_rw), .req0_wdata(d3_req0_wdata),
    .req1_valid(1'b0), .req1_ready(d3_req1_ready), .req1_write(1'b0),
    .req1_ra(4'd0), .req1_rb(4'd0), .req1_rw(4'd0), .req1_wdata(32'd0),
    .rsp_valid(d3_rsp_valid), .rsp_id(d3_rsp_id), .rsp_write(d3_rsp_write), .rsp_err(d3_rsp_err),
    .rsp_a(d3_rsp_a), .rsp_b(d3_rsp_b),
    .rf_RegWr(d3_rf_RegWr), .rf_RA(d3_rf_RA), .rf_RB(d3_rf_RB), .rf_RW(d3_rf_RW),
    .rf_BusW(d3_rf_BusW), .rf_BusA(d3_rf_BusA), .rf_BusB(d3_rf_BusB)
  );

  // Clock generation, 10 time-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural register files. Contents are not reset; they are loaded with
  // R[i] = i on the first edge. Writes commit at the edge where RegWr is
  // high. Reads are registered: one stage for d1, three stages for d3.
  logic [31:0] rf1 [16];
  logic [31:0] rf3 [16];
  logic [31:0] d3_s1a, d3_s2a, d3_s1b, d3_s2b;
  logic        rf_init = 1'b0;

  always @(posedge clock) begin
    if (!rf_init) begin
      for (int i = 0; i < 16; i++) begin
        rf1[i] <= 32'(i);
        rf3[i] <= 32'(i);
      end
      rf_init <= 1'b1;
    end else begin
      if (d1_rf_RegWr && (d1_rf_RW != '0)) rf1[d1_rf_RW] <= d1_rf_BusW;
      if (d3_rf_RegWr && (d3_rf_RW != '0)) rf3[d3_rf_RW] <= d3_rf_BusW;
    end
    d1_rf_BusA <= rf1[d1_rf_RA];
    d1_rf_BusB <= rf1[d1_rf_RB];
    d3_s1a     <= rf3[d3_rf_RA];
    d3_s1b     <= rf3[d3_rf_RB];
    d3_s2a     <= d3_s1a;
    d3_s2b     <= d3_s1b;
    d3_rf_BusA <= d3_s2a;
    d3_rf_BusB <= d3_s2b;
  end

  // Runaway guard.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got running want finished");
    $fatal(1, "[TB] global timeout");
  end

  // Drives one operation on d1 (requester id) or on d3 (requester 0), waits
  // for the grant, and then waits for the response. It returns to the caller
  // at the falling edge where rsp_valid is seen. edges counts rising edges
  // from the accept edge to the response; regwr_cnt counts falling edges with
  // the write strobe high.
  task automatic run_op(input bit on3, input bit id, input bit wr,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] rw, input logic [31:0] wd,
                        output bit granted, output int edges, output int regwr_cnt);
    bit rdy;
    granted   = 1'b0;
    edges     = 0;
    regwr_cnt = 0;
    if (on3) begin
      d3_req0_write = wr; d3_req0_ra = ra; d3_req0_rb = rb;
      d3_req0_rw = rw; d3_req0_wdata = wd; d3_req0_valid = 1'b1;
    end else if (id) begin
      d1_req1_write = wr; d1_req1_ra = ra; d1_req1_rb = rb;
      d1_req1_rw = rw; d1_req1_wdata = wd; d1_req1_valid = 1'b1;
    end else begin
      d1_req0_write = wr; d1_req0_ra = ra; d1_req0_rb = rb;
      d1_req0_rw = rw; d1_req0_wdata = wd; d1_req0_valid = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      #1;
      rdy = on3 ? d3_req0_ready : (id ? d1_req1_ready : d1_req0_ready);
      if (rdy) begin
        granted = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (granted) begin
      @(posedge clock);
      @(negedge clock);
    end
    if (on3) d3_req0_valid = 1'b0;
    else if (id) d1_req1_valid = 1'b0;
    else d1_req0_valid = 1'b0;
    if (granted) begin
      for (int i = 0; i < 10; i++) begin
        if (on3 ? d3_rf_RegWr : d1_rf_RegWr) regwr_cnt++;
        @(posedge clock);
        edges++;
        @(negedge clock);
        if (on3 ? d3_rsp_valid : d1_rsp_valid) break;
      end
      if (on3 ? d3_rf_RegWr : d1_rf_RegWr) regwr_cnt++;
    end
  endtask

  // Reset holds everything at zero, then a lone req1 is granted combinationally.
  task automatic test_reset();
    bit g; int e, n;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    tests_run++;
    if ({d1_rsp_valid, d1_rsp_id, d1_rsp_write, d1_rsp_err, d1_rsp_a, d1_rsp_b} !== 68'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_rsp: got v=%b a=%h b=%h want all zero", d1_rsp_valid, d1_rsp_a, d1_rsp_b);
    end
    tests_run++;
    if ({d1_rf_RegWr, d1_rf_RA, d1_rf_RB, d1_rf_RW, d1_rf_BusW} !== 45'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_rf: got we=%b RA=%h RB=%h RW=%h BusW=%h want all zero",
               d1_rf_RegWr, d1_rf_RA, d1_rf_RB, d1_rf_RW, d1_rf_BusW);
    end
    tests_run++;
    if ({d1_req0_ready, d1_req1_ready, d3_req0_ready, d3_req1_ready} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready: got %b want 0000",
               {d1_req0_ready, d1_req1_ready, d3_req0_ready, d3_req1_ready});
    end
    tests_run++;
    if ({d3_rsp_valid, d3_rsp_a, d3_rf_RegWr, d3_rf_RW, d3_rf_BusW} !== 70'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_d3: got v=%b a=%h we=%b want all zero", d3_rsp_valid, d3_rsp_a, d3_rf_RegWr);
    end
    reset = 1'b0;
    d1_req1_write = 1'b0; d1_req1_ra = 4'd3; d1_req1_rb = 4'd4; d1_req1_valid = 1'b1;
    #1;
    tests_run++;
    if ({d1_req1_ready, d1_req0_ready} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL release_ready: got r1r0=%b want 10", {d1_req1_ready, d1_req0_ready});
    end
    run_op(1'b0, 1'b1, 1'b0, 4'd3, 4'd4, 4'd0, 32'd0, g, e, n);
    tests_run++;
    if ({e, d1_rsp_id, d1_rsp_a, d1_rsp_b} !== {32'd2, 1'b1, 32'd3, 32'd4}) begin
      tests_failed++;
      $display("[TB] FAIL release_read: got edges=%0d id=%b a=%h b=%h want 2 1 3 4", e, d1_rsp_id, d1_rsp_a, d1_rsp_b);
    end
  endtask

  // Write R1 then read R1/R2 on requester 0.
  task automatic test_write_read();
    bit g; int e, n;
    run_op(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd1, 32'hAAAAAAAA, g, e, n);
    tests_run++;
    if (e !== 1) begin
      tests_failed++;
      $display("[TB] FAIL wr_latency: got %0d edges want 1", e);
    end
    tests_run++;
    if (n !== 1) begin
      tests_failed++;
      $display("[TB] FAIL wr_regwr_cycles: got %0d want 1", n);
    end
    tests_run++;
    if ({d1_rsp_write, d1_rsp_err, d1_rsp_id, d1_rsp_a, d1_rsp_b} !== {3'b100, 64'd0}) begin
      tests_failed++;
      $display("[TB] FAIL wr_rsp: got w/e/id=%b%b%b a=%h b=%h want 100 0 0",
               d1_rsp_write, d1_rsp_err, d1_rsp_id, d1_rsp_a, d1_rsp_b);
    end
    run_op(1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0, 32'd0, g, e, n);
    tests_run++;
    if (e !== 2) begin
      tests_failed++;
      $display("[TB] FAIL rd_latency: got %0d edges want 2", e);
    end
    tests_run++;
    if ({d1_rsp_write, d1_rsp_a, d1_rsp_b} !== {1'b0, 32'hAAAAAAAA, 32'd2}) begin
      tests_failed++;
      $display("[TB] FAIL rd_data: got w=%b a=%h b=%h want 0 aaaaaaaa 00000002", d1_rsp_write, d1_rsp_a, d1_rsp_b);
    end
    @(negedge clock);
    tests_run++;
    if ({d1_rsp_valid, d1_rsp_a} !== {1'b0, 32'hAAAAAAAA}) begin
      tests_failed++;
      $display("[TB] FAIL rsp_pulse_hold: got v=%b a=%h want 0 aaaaaaaa", d1_rsp_valid, d1_rsp_a);
    end
  endtask

  // Both requesters valid for four reads: grants alternate 0,1,0,1.
  task automatic test_round_robin();
    bit g; int e, n;
    bit exp_id, both_high, seen;
    // A lone req1 op leaves req0 as the favoured requester for the first tie.
    run_op(1'b0, 1'b1, 1'b0, 4'd5, 4'd6, 4'd0, 32'd0, g, e, n);
    d1_req0_write = 1'b0; d1_req0_ra = 4'd1; d1_req0_rb = 4'd3; d1_req0_valid = 1'b1;
    d1_req1_write = 1'b0; d1_req1_ra = 4'd5; d1_req1_rb = 4'd6; d1_req1_valid = 1'b1;
    both_high = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_id = ((k % 2) == 1);
      for (int w = 0; w < 4; w++) begin
        #1;
        if (d1_req0_ready && d1_req1_ready) both_high = 1'b1;
        if (d1_req0_ready || d1_req1_ready) break;
        @(negedge clock);
      end
      tests_run++;
      if ({d1_req1_ready, d1_req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
        tests_failed++;
        $display("[TB] FAIL rr_grant%0d: got r1r0=%b want id %0d", k, {d1_req1_ready, d1_req0_ready}, exp_id);
      end
      @(posedge clock);
      @(negedge clock);
      if (k == 3) begin
        d1_req0_valid = 1'b0;
        d1_req1_valid = 1'b0;
      end
      seen = 1'b0;
      for (int w = 0; w < 6; w++) begin
        if (d1_req0_ready && d1_req1_ready) both_high = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if (d1_rsp_valid) begin
          seen = 1'b1;
          break;
        end
      end
      tests_run++;
      if ({seen, d1_rsp_id, d1_rsp_a} !== {1'b1, exp_id, (exp_id ? 32'd5 : 32'hAAAAAAAA)}) begin
        tests_failed++;
        $display("[TB] FAIL rr_rsp%0d: got seen=%b id=%b a=%h want id %0d", k, seen, d1_rsp_id, d1_rsp_a, exp_id);
      end
    end
    tests_run++;
    if (both_high !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rr_both_ready: got %b want 0", both_high);
    end
  endtask

  // A write to R0 is dropped and flagged; R0 still reads as zero.
  task automatic test_r0_write();
    bit g; int e, n;
    run_op(1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 32'hFFFFFFFF, g, e, n);
    tests_run++;
    if (n !== 0) begin
      tests_failed++;
      $display("[TB] FAIL r0_regwr: got %0d strobe cycles want 0", n);
    end
    tests_run++;
    if ({e, d1_rsp_write, d1_rsp_err, d1_rsp_id} !== {32'd1, 3'b111}) begin
      tests_failed++;
      $display("[TB] FAIL r0_rsp: got edges=%0d w/e/id=%b%b%b want 1 111", e, d1_rsp_write, d1_rsp_err, d1_rsp_id);
    end
    run_op(1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 32'd0, g, e, n);
    tests_run++;
    if ({d1_rsp_a, d1_rsp_b} !== {32'd0, 32'hAAAAAAAA}) begin
      tests_failed++;
      $display("[TB] FAIL r0_read: got a=%h b=%h want 00000000 aaaaaaaa", d1_rsp_a, d1_rsp_b);
    end
  endtask

  // Read straight after a write sees the new value, for RD_LAT 1 and 3.
  task automatic test_back_to_back();
    bit g; int e, n;
    run_op(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 32'h0F0F0F0F, g, e, n);
    run_op(1'b0, 1'b0, 1'b0, 4'd7, 4'd2, 4'd0, 32'd0, g, e, n);
    tests_run++;
    if ({e, d1_rsp_a, d1_rsp_b} !== {32'd2, 32'h0F0F0F0F, 32'd2}) begin
      tests_failed++;
      $display("[TB] FAIL raw_lat1: got edges=%0d a=%h b=%h want 2 0f0f0f0f 00000002", e, d1_rsp_a, d1_rsp_b);
    end
    run_op(1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 32'h0F0F0F0F, g, e, n);
    tests_run++;
    if ({e, n, d3_rsp_write, d3_rsp_err} !== {32'd1, 32'd1, 2'b10}) begin
      tests_failed++;
      $display("[TB] FAIL raw_lat3_wr: got edges=%0d strobes=%0d w=%b e=%b want 1 1 1 0", e, n, d3_rsp_write, d3_rsp_err);
    end
    run_op(1'b1, 1'b0, 1'b0, 4'd7, 4'd2, 4'd0, 32'd0, g, e, n);
    tests_run++;
    if (e !== 4) begin
      tests_failed++;
      $display("[TB] FAIL raw_lat3_latency: got %0d edges want 4", e);
    end
    tests_run++;
    if ({d3_rsp_a, d3_rsp_b} !== {32'h0F0F0F0F, 32'd2}) begin
      tests_failed++;
      $display("[TB] FAIL raw_lat3_data: got a=%h b=%h want 0f0f0f0f 00000002", d3_rsp_a, d3_rsp_b);
    end
  endtask

  // Reset during the WRITE cycle suppresses the write and the response.
  task automatic test_reset_mid_write();
    bit g; int e, n;
    bit seen;
    d1_req0_write = 1'b1; d1_req0_rw = 4'd5; d1_req0_wdata = 32'h12345678; d1_req0_valid = 1'b1;
    #1;
    tests_run++;
    if (d1_req0_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midrst_grant: got ready=%b want 1", d1_req0_ready);
    end
    @(posedge clock);
    @(negedge clock);
    d1_req0_valid = 1'b0;
    reset = 1'b1;
    #1;
    tests_run++;
    if (d1_rf_RegWr !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_regwr: got %b want 0", d1_rf_RegWr);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    seen = d1_rsp_valid;
    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
      seen = seen | d1_rsp_valid;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_rsp: got rsp_valid=%b want 0", seen);
    end
    run_op(1'b0, 1'b0, 1'b0, 4'd5, 4'd7, 4'd0, 32'd0, g, e, n);
    tests_run++;
    if ({e, d1_rsp_a, d1_rsp_b} !== {32'd2, 32'd5, 32'h0F0F0F0F}) begin
      tests_failed++;
      $display("[TB] FAIL midrst_r5: got edges=%0d a=%h b=%h want 2 00000005 0f0f0f0f", e, d1_rsp_a, d1_rsp_b);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b1;
    d1_req0_valid = 1'b0; d1_req0_write = 1'b0; d1_req0_ra = 4'd0; d1_req0_rb = 4'd0;
    d1_req0_rw = 4'd0; d1_req0_wdata = 32'd0;
    d1_req1_valid = 1'b0; d1_req1_write = 1'b0; d1_req1_ra = 4'd0; d1_req1_rb = 4'd0;
    d1_req1_rw = 4'd0; d1_req1_wdata = 32'd0;
    d3_req0_valid = 1'b0; d3_req0_write = 1'b0; d3_req0_ra = 4'd0; d3_req0_rb = 4'd0;
    d3_req0_rw = 4'd0; d3_req0_wdata = 32'd0;

    test_reset();
    test_write_read();
    test_round_robin();
    test_r0_write();
    test_back_to_back();
    test_reset_mid_write();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
